// File: rtl/iob_ethoc_ctrl_pkg.sv
`timescale 1ns/1ps
// iob_ethoc_ctrl_pkg: shared definitions for the ethmac bring-up/frame sequencer.
// Holds the FSM state encoding, ethmac register byte addresses, buffer-descriptor
// control words and INT_SOURCE bit positions.
package iob_ethoc_ctrl_pkg;

  typedef enum logic [3:0] {
    INIT_IMASK,
    INIT_RXPTR,
    INIT_RXBD,
    INIT_MODER,
    IDLE,
    TX_PTR,
    TX_BD,
    WAIT_IRQ,
    RD_ISRC,
    CLR_ISRC,
    RD_RXBD,
    REARM_PTR,
    REARM_BD,
    DONE
  } state_e;

  // ethmac register / BD byte addresses
  localparam logic [11:0] REG_MODER      = 12'h000;
  localparam logic [11:0] REG_INT_SOURCE = 12'h004;
  localparam logic [11:0] REG_INT_MASK   = 12'h008;
  localparam logic [11:0] REG_TXBD0_CTRL = 12'h400;
  localparam logic [11:0] REG_TXBD0_PTR  = 12'h404;
  localparam logic [11:0] REG_RXBD0_CTRL = 12'h600;
  localparam logic [11:0] REG_RXBD0_PTR  = 12'h604;

  // RX BD: E, IRQ, WR.  TX BD low half: RD, IRQ, WR, PAD, CRC.
  localparam logic [31:0] RXBD_CTRL    = 32'h0000E000;
  localparam logic [15:0] TXBD_CTRL_LO = 16'hF800;
  localparam logic [31:0] INT_MASK_ALL = 32'h0000007F;

  localparam int unsigned ISRC_TXB = 0;
  localparam int unsigned ISRC_TXE = 1;
  localparam int unsigned ISRC_RXB = 2;
  localparam int unsigned ISRC_RXE = 3;

  // A frame is finished once both a TX event and an RX event have been seen.
  function automatic logic frame_complete(input logic [6:0] st);
    return (st[ISRC_TXB] | st[ISRC_TXE]) & (st[ISRC_RXB] | st[ISRC_RXE]);
  endfunction

endpackage

// File: rtl/iob_ethoc_ctrl_bus.sv
`timescale 1ns/1ps
// iob_ethoc_ctrl_bus: single-outstanding iob native bus master.
// Command side : req/we/addr/wdata, accepted when no transaction is pending.
// Response side: ack pulses in the m_ready_i cycle; rdata is m_rdata_i in that cycle.
// Bus side     : m_valid_o is high for exactly one cycle per access; address,
//                wdata and wstrb are held until m_ready_i.
module iob_ethoc_ctrl_bus
  import iob_ethoc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_address_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i
);

  logic pending;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      m_valid_o   <= 1'b0;
      pending     <= 1'b0;
      m_address_o <= '0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
    end else begin
      m_valid_o <= 1'b0;
      if (!pending && req) begin
        m_valid_o   <= 1'b1;
        pending     <= 1'b1;
        m_address_o <= addr;
        m_wdata_o   <= we ? wdata : '0;
        m_wstrb_o   <= we ? '1 : '0;
      end else if (ack) begin
        pending <= 1'b0;
      end
    end
  end

  // A ready coinciding with the strobe cycle is not a legal response.
  assign ack   = pending & m_ready_i & ~m_valid_o;
  assign rdata = m_rdata_i;

endmodule

// File: rtl/iob_ethoc_ctrl.sv
`timescale 1ns/1ps
// iob_ethoc_ctrl: hardware sequencer driving ethmac over the iob bus.
// Performs MAC init after reset, then per start_i: arms TX BD0, waits for the
// interrupt, services INT_SOURCE (read + write-1-to-clear) until both a TX and
// an RX event are seen, reads RX BD0 length and rearms it, pulses done_o.
// Host ports : start_i, tx_ptr_i, tx_len_i, rx_ptr_i -> busy_o, done_o,
//              status_o, rx_len_o, timeout_o.
// Bus ports  : m_valid_o, m_address_o, m_wdata_o, m_wstrb_o, m_rdata_i, m_ready_i.
// Interrupt  : eth_int_i (level).
module iob_ethoc_ctrl
  import iob_ethoc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] MODER_VAL   = 32'h0000A403,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic [31:0]         tx_ptr_i,
  input  logic [15:0]         tx_len_i,
  input  logic [31:0]         rx_ptr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [6:0]          status_o,
  output logic [15:0]         rx_len_o,
  output logic                timeout_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_address_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_ready_i,
  input  logic                eth_int_i
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state, state_nx;
  logic [31:0]         tx_ptr;
  logic [15:0]         tx_len;
  logic [DATA_W-1:0]   isrc;
  logic [6:0]          status;
  logic [15:0]         rx_len;
  logic                timeout;
  logic [TMO_W-1:0]    tmo_cnt;

  logic                req, we, ack;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata, rdata;

  logic                tmo_expire;
  assign tmo_expire = !eth_int_i && (tmo_cnt <= TMO_W'(1));

  iob_ethoc_ctrl_bus #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .m_valid_o   (m_valid_o),
    .m_address_o (m_address_o),
    .m_wdata_o   (m_wdata_o),
    .m_wstrb_o   (m_wstrb_o),
    .m_rdata_i   (m_rdata_i),
    .m_ready_i   (m_ready_i)
  );

  // Every bus state holds req until ack; the bus master issues only once.
  always_comb begin
    state_nx = state;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    unique case (state)
      INIT_IMASK: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_INT_MASK); wdata = DATA_W'(INT_MASK_ALL);
        if (ack) state_nx = INIT_RXPTR;
      end
      INIT_RXPTR: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_RXBD0_PTR); wdata = DATA_W'(rx_ptr_i);
        if (ack) state_nx = INIT_RXBD;
      end
      INIT_RXBD: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_RXBD0_CTRL); wdata = DATA_W'(RXBD_CTRL);
        if (ack) state_nx = INIT_MODER;
      end
      INIT_MODER: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_MODER); wdata = DATA_W'(MODER_VAL);
        if (ack) state_nx = IDLE;
      end
      IDLE: begin
        if (start_i) state_nx = TX_PTR;
      end
      TX_PTR: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_TXBD0_PTR); wdata = DATA_W'(tx_ptr);
        if (ack) state_nx = TX_BD;
      end
      TX_BD: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_TXBD0_CTRL); wdata = DATA_W'({tx_len, TXBD_CTRL_LO});
        if (ack) state_nx = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        if (eth_int_i)       state_nx = RD_ISRC;
        else if (tmo_expire) state_nx = DONE;
      end
      RD_ISRC: begin
        req = 1'b1; addr = ADDR_W'(REG_INT_SOURCE);
        if (ack) state_nx = (rdata[6:0] == 7'd0) ? WAIT_IRQ : CLR_ISRC;
      end
      CLR_ISRC: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_INT_SOURCE); wdata = isrc;
        if (ack) state_nx = frame_complete(status) ? RD_RXBD : WAIT_IRQ;
      end
      RD_RXBD: begin
        req = 1'b1; addr = ADDR_W'(REG_RXBD0_CTRL);
        if (ack) state_nx = REARM_PTR;
      end
      REARM_PTR: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_RXBD0_PTR); wdata = DATA_W'(rx_ptr_i);
        if (ack) state_nx = REARM_BD;
      end
      REARM_BD: begin
        req = 1'b1; we = 1'b1; addr = ADDR_W'(REG_RXBD0_CTRL); wdata = DATA_W'(RXBD_CTRL);
        if (ack) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = INIT_IMASK;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state   <= INIT_IMASK;
      tx_ptr  <= '0;
      tx_len  <= '0;
      isrc    <= '0;
      status  <= '0;
      rx_len  <= '0;
      timeout <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            tx_ptr  <= tx_ptr_i;
            tx_len  <= tx_len_i;
            status  <= '0;
            timeout <= 1'b0;
          end
        end
        TX_BD: begin
          if (ack) tmo_cnt <= TMO_W'(TIMEOUT_CYC);
        end
        // Budget is per frame: it only counts down here and is never reloaded
        // when an ISR pass returns to WAIT_IRQ.
        WAIT_IRQ: begin
          if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);
          if (tmo_expire)    timeout <= 1'b1;
        end
        RD_ISRC: begin
          if (ack) begin
            isrc   <= rdata;
            status <= status | rdata[6:0];
          end
        end
        RD_RXBD: begin
          if (ack) rx_len <= rdata[31:16];
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign status_o  = status;
  assign rx_len_o  = rx_len;
  assign timeout_o = timeout;

endmodule

// File: tb/tb_iob_ethoc_ctrl.sv
`timescale 1ns/1ps
module tb_iob_ethoc_ctrl;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] tx_ptr_i = '0;
  logic [15:0] tx_len_i = '0;
  logic [31:0] rx_ptr_i = '0;
  logic        busy_o, done_o, timeout_o, m_valid_o;
  logic [6:0]  status_o;
  logic [15:0] rx_len_o;
  logic [11:0] m_address_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic [31:0] m_rdata_i = '0;
  logic        m_ready_i = 1'b0;
  logic        eth_int_i = 1'b0;

  // reference model state
  acc_t        exp_q[$];
  logic [31:0] plan[$];
  logic [31:0] irq_vals[$];
  logic [31:0] rxbd_word = '0;
  logic [6:0]  exp_status = '0;
  logic [15:0] exp_rx_len = '0;
  logic        exp_timeout = 1'b0;
  bit          fixed_lat = 1'b1;
  int          done_cnt = 0, done_cyc = 0, txbd_rdy_cyc = 0, cyc = 0;
  int          checks = 0, failures = 0;

  iob_ethoc_ctrl #(
    .ADDR_W      (12),
    .DATA_W      (32),
    .MODER_VAL   (32'h0000A403),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n_i),
    .start_i     (start_i),
    .tx_ptr_i    (tx_ptr_i),
    .tx_len_i    (tx_len_i),
    .rx_ptr_i    (rx_ptr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .status_o    (status_o),
    .rx_len_o    (rx_len_o),
    .timeout_o   (timeout_o),
    .m_valid_o   (m_valid_o),
    .m_address_o (m_address_o),
    .m_wdata_o   (m_wdata_o),
    .m_wstrb_o   (m_wstrb_o),
    .m_rdata_i   (m_rdata_i),
    .m_ready_i   (m_ready_i),
    .eth_int_i   (eth_int_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic we, input logic [11:0] a, input logic [31:0] d);
    acc_t e;
    e.we = we; e.addr = a; e.wdata = d;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push(1'b1, 12'h008, 32'h0000007F);
    push(1'b1, 12'h604, rx_ptr_i);
    push(1'b1, 12'h600, 32'h0000E000);
    push(1'b1, 12'h000, 32'h0000A403);
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle"}, busy_o, 0);
    chk({nm, "_all_accesses_seen"}, exp_q.size(), 0);
  endtask

  // Model of one frame from the host's point of view: the access list follows
  // from the interrupt plan, and the outcome is completion or timeout.
  task automatic run_frame(input logic [31:0] tp, input logic [15:0] tl,
                           input logic [31:0] rxw, input bit pulse_mid);
    logic [6:0] st;
    bit         fin;
    int         n0, k;
    st = '0;
    fin = 1'b0;
    irq_vals.delete();
    push(1'b1, 12'h404, tp);
    push(1'b1, 12'h400, {tl, 16'hF800});
    foreach (plan[i]) begin
      if (!fin) begin
        irq_vals.push_back(plan[i]);
        push(1'b0, 12'h004, '0);
        if (plan[i][6:0] != 7'd0) begin
          st = st | plan[i][6:0];
          push(1'b1, 12'h004, plan[i]);
          if ((st[0] | st[1]) && (st[2] | st[3])) begin
            fin = 1'b1;
            push(1'b0, 12'h600, '0);
            push(1'b1, 12'h604, rx_ptr_i);
            push(1'b1, 12'h600, 32'h0000E000);
          end
        end
      end
    end
    exp_status  = st;
    exp_timeout = !fin;
    if (fin) exp_rx_len = rxw[31:16];
    rxbd_word = rxw;
    n0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; tx_ptr_i = tp; tx_len_i = tl;
    @(negedge clk);
    start_i = 1'b0; tx_ptr_i = $urandom; tx_len_i = 16'($urandom);
    if (pulse_mid) begin
      repeat (10) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    k = 0;
    while (done_cnt == n0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_done_seen", done_cnt, n0 + 1);
    @(negedge clk);
    chk("idle_after_done", busy_o, 0);
  endtask

  // Slave, interrupt source and per-cycle compare, all sampled on negedge.
  initial begin : slave
    acc_t        e;
    bit          outst, prev_done;
    int          wait_cnt, irq_wait;
    logic [11:0] p_addr;
    logic [31:0] p_wdata, p_rdata, cur_isrc;
    logic [3:0]  p_wstrb;
    outst = 0; prev_done = 0; wait_cnt = 0; irq_wait = 0;
    p_addr = '0; p_wdata = '0; p_rdata = '0; cur_isrc = '0; p_wstrb = '0;
    forever begin
      @(negedge clk);
      m_ready_i = 1'b0;
      if (!arst_n_i) begin
        outst = 0; irq_wait = 0; eth_int_i = 1'b0; prev_done = 0;
        irq_vals.delete();
        continue;
      end
      if (irq_wait > 0) begin
        irq_wait--;
        if (irq_wait == 0 && irq_vals.size() > 0) begin
          cur_isrc = irq_vals.pop_front();
          eth_int_i = 1'b1;
        end
      end
      if (outst) begin
        chk("hold_addr", m_address_o, p_addr);
        chk("hold_wdata", m_wdata_o, p_wdata);
        chk("hold_wstrb", m_wstrb_o, p_wstrb);
        if (wait_cnt == 0) begin
          m_ready_i = 1'b1;
          m_rdata_i = p_rdata;
          outst = 0;
          if (p_wstrb == 4'hf && p_addr == 12'h400) txbd_rdy_cyc = cyc;
        end else begin
          wait_cnt--;
        end
      end
      if (m_valid_o) begin
        chk("single_outstanding", outst, 0);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_access actual=addr 0x%0h wstrb 0x%0h required=no access", m_address_o, m_wstrb_o);
        end else begin
          e = exp_q.pop_front();
          chk("acc_addr", m_address_o, e.addr);
          chk("acc_wstrb", m_wstrb_o, e.we ? 4'hf : 4'h0);
          if (e.we) chk("acc_wdata", m_wdata_o, e.wdata);
        end
        p_addr = m_address_o; p_wdata = m_wdata_o; p_wstrb = m_wstrb_o;
        outst = 1;
        wait_cnt = fixed_lat ? 1 : int'($urandom_range(0, 3));
        p_rdata = 32'hBAD0_0000;
        if (m_wstrb_o == 4'h0) begin
          if (m_address_o == 12'h004) begin
            p_rdata = cur_isrc;
            if (cur_isrc[6:0] == 7'd0) begin
              eth_int_i = 1'b0;
              if (irq_vals.size() > 0) irq_wait = $urandom_range(1, 6);
            end
          end else if (m_address_o == 12'h600) begin
            p_rdata = rxbd_word;
          end
        end else if (m_address_o == 12'h004) begin
          cur_isrc = cur_isrc & ~m_wdata_o;
          if (cur_isrc[6:0] == 7'd0) begin
            eth_int_i = 1'b0;
            if (irq_vals.size() > 0) irq_wait = $urandom_range(1, 6);
          end
        end else if (m_address_o == 12'h400) begin
          if (irq_vals.size() > 0) irq_wait = $urandom_range(1, 6);
        end
      end
      if (done_o) begin
        chk("done_pulse_width", prev_done, 0);
        chk("done_status", status_o, exp_status);
        chk("done_rx_len", rx_len_o, exp_rx_len);
        chk("done_timeout", timeout_o, exp_timeout);
        chk("done_accesses_complete", exp_q.size(), 0);
        done_cyc = cyc;
        done_cnt++;
      end
      prev_done = done_o;
    end
  end

  initial begin : main
    int          seen, n;
    logic [31:0] r, v;
    rx_ptr_i = 32'h0000_8000;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_wstrb", m_wstrb_o, 0);
    chk("rst_m_address", m_address_o, 0);
    chk("rst_m_wdata", m_wdata_o, 0);
    chk("rst_busy", busy_o, 1);
    chk("rst_done", done_o, 0);
    chk("rst_status", status_o, 0);
    chk("rst_rx_len", rx_len_o, 0);
    chk("rst_timeout", timeout_o, 0);

    push_init();
    arst_n_i = 1'b1;
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle("init");

    plan.delete(); plan.push_back(32'h5);
    run_frame(32'h0000F000, 16'h0020, 32'h00246000, 1'b0);
    chk("f1_rx_len", rx_len_o, 16'h0024);
    chk("f1_status", status_o, 7'h05);
    chk("f1_timeout", timeout_o, 0);

    plan.delete(); plan.push_back(32'h1); plan.push_back(32'h4);
    run_frame(32'h0000A000, 16'h0100, 32'h00406000, 1'b0);
    chk("f2_status", status_o, 7'h05);
    chk("f2_rx_len", rx_len_o, 16'h0040);

    plan.delete();
    run_frame(32'h00001234, 16'h0040, 32'hFFFF6000, 1'b1);
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_latency", done_cyc - txbd_rdy_cyc, 51);
    chk("tmo_rx_len_kept", rx_len_o, 16'h0040);
    chk("tmo_status", status_o, 7'h00);

    fixed_lat = 1'b0;
    for (int f = 0; f < 25; f++) begin
      plan.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        r = $urandom;
        case ($urandom_range(0, 3))
          0:       v = r & 32'hFFFF_FF80;
          1:       v = (r & 32'hFFFF_FF80) | (32'h1 << $urandom_range(0, 6));
          default: v = r;
        endcase
        plan.push_back(v);
      end
      rx_ptr_i = $urandom;
      run_frame($urandom, 16'($urandom), $urandom, 1'b0);
    end

    // Reset while a request is on the bus: strobe must fall without a clock.
    arst_n_i = 1'b0;
    @(negedge clk);
    exp_q.delete();
    rx_ptr_i = 32'h0000_C000;
    push_init();
    arst_n_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && seen < 2; i++) begin
      @(negedge clk);
      if (m_valid_o) seen++;
    end
    chk("rst_mid_found_request", seen, 2);
    #1 arst_n_i = 1'b0;
    #1;
    chk("rst_mid_valid_async", m_valid_o, 0);
    chk("rst_mid_address", m_address_o, 0);
    chk("rst_mid_busy", busy_o, 1);
    @(negedge clk);
    exp_q.delete();
    push_init();
    exp_status = '0; exp_rx_len = '0; exp_timeout = 1'b0;
    repeat (2) @(negedge clk);
    arst_n_i = 1'b1;
    wait_idle("reinit");

    plan.delete(); plan.push_back(32'h3); plan.push_back(32'h8);
    run_frame(32'h0000B000, 16'h0044, 32'h00886000, 1'b0);
    chk("f_last_status", status_o, 7'h0B);
    chk("f_last_rx_len", rx_len_o, 16'h0088);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_ethoc_ctrl.md
Name: iob_ethoc_ctrl

Overview:
- Hardware sequencer that drives the ethmac register/BD space over the iob native bus as a bus master.
- Replaces software-driven bring-up and per-frame handling with a fixed sequence: init, TX BD0 arm, interrupt wait, INT_SOURCE service and RX BD0 readback/rearm.
- Sits between a simple host command port (start/done) and the slave port of iob_ethoc; single outstanding bus transaction.

Parameters:
- ADDR_W, 12, master address width (byte address).
- DATA_W, 32, bus data width; only 32 supported.
- MODER_VAL, 32'h0000A403, value written to MODER at init (PAD, CRCEN, FULLD, TXEN, RXEN).
- TIMEOUT_CYC, 100000, clk_i cycles allowed in WAIT_IRQ per frame.

Ports:
- clk_i  in  1  system clock.
- arst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  start one frame; sampled only in IDLE.
- tx_ptr_i  in  32  TX buffer pointer, captured on accepted start.
- tx_len_i  in  16  TX length in bytes, captured on accepted start.
- rx_ptr_i  in  32  RX buffer pointer, used at init and rearm.
- busy_o  out  1  high outside IDLE, including init.
- done_o  out  1  one-cycle pulse at end of frame.
- status_o  out  7  accumulated INT_SOURCE bits [6:0] for the last frame.
- rx_len_o  out  16  RX BD0 LEN field from the last frame.
- timeout_o  out  1  last frame ended by timeout.
- m_valid_o  out  1  iob request strobe.
- m_address_o  out  ADDR_W  request byte address.
- m_wdata_o  out  32  write data.
- m_wstrb_o  out  4  4'hf for writes, 4'h0 for reads.
- m_rdata_i  in  32  read data, valid when m_ready_i=1.
- m_ready_i  in  1  transaction complete.
- eth_int_i  in  1  ethmac interrupt, level.

Behaviour:
- Reset values:
  - m_valid_o=0, m_wstrb_o=0, m_address_o=0, m_wdata_o=0.
  - busy_o=1, done_o=0, status_o=0, rx_len_o=0, timeout_o=0.
  - FSM enters INIT_IMASK.
- Bus access:
  - Each access asserts m_valid_o for exactly one cycle.
  - address, wdata and wstrb hold until m_ready_i=1.
  - m_ready_i is never expected in the same cycle as m_valid_o.
  - m_rdata_i is captured in the m_ready_i cycle.
  - The next access issues no earlier than the cycle after m_ready_i.
- Register addresses (byte): MODER 0x000, INT_SOURCE 0x004, INT_MASK 0x008, TXBD0 0x400/0x404, RXBD0 0x600/0x604.
- Init sequence (writes):
  - INIT_IMASK: 0x008 <= 0x7F.
  - INIT_RXPTR: 0x604 <= rx_ptr_i.
  - INIT_RXBD: 0x600 <= 0x0000E000 (E, IRQ, WR).
  - INIT_MODER: 0x000 <= MODER_VAL.
  - Then IDLE, busy_o=0.
- IDLE:
  - start_i=1 captures tx_ptr_i/tx_len_i, clears status_o and timeout_o, goes to TX_PTR.
  - start_i in any other state is ignored.
- TX_PTR: 0x404 <= tx_ptr.
- TX_BD: 0x400 <= {tx_len, 16'hF800} (RD, IRQ, WR, PAD, CRC). Then WAIT_IRQ; timeout counter loads TIMEOUT_CYC.
- WAIT_IRQ:
  - eth_int_i=1 goes to RD_ISRC.
  - Counter reaching 0 sets timeout_o=1 and goes to DONE. Counter keeps running across ISR service loops.
- RD_ISRC:
  - Read 0x004 into isrc.
  - isrc[6:0]==0 (spurious) returns to WAIT_IRQ.
  - Otherwise status_o |= isrc[6:0], then CLR_ISRC.
- CLR_ISRC:
  - 0x004 <= isrc (write-1-to-clear).
  - If status_o has (bit0|bit1) AND (bit2|bit3), go to RD_RXBD; otherwise go to WAIT_IRQ.
- RD_RXBD: read 0x600; rx_len_o <= rdata[31:16].
- REARM_PTR: 0x604 <= rx_ptr_i.
- REARM_BD: 0x600 <= 0x0000E000.
- DONE: done_o=1 for one cycle, then IDLE.
- Timeout path skips RD_RXBD and rearm; RX BD0 state is left as is.
- Reset mid-operation: all state returns to reset values next edge. m_valid_o drops asynchronously; any in-flight slave response is ignored.

Decomposition:
- Package iob_ethoc_ctrl_pkg holds:
  - State encoding enum (14 states).
  - Register byte addresses.
  - BD control constants RXBD_CTRL=0x0000E000 and TXBD_CTRL_LO=16'hF800.
  - INT_SOURCE bit indices: TXB=0, TXE=1, RXB=2, RXE=3.
- One sub-module, iob_ethoc_ctrl_bus: a single-transaction iob master.
  - Command side: req, we, addr, wdata.
  - Response side: ack pulse, rdata.
  - Holds the one-cycle-valid and hold-until-ready rules.
- The FSM only sequences commands to iob_ethoc_ctrl_bus.

Test Plan:
- Reset release with a slave model returning ready 2 cycles after valid -> exactly 4 writes in order (0x008=0x7F, 0x604=rx_ptr, 0x600=0xE000, 0x000=0xA403), then busy_o=0.
- start_i with tx_ptr=0xF000, tx_len=0x20; model raises eth_int_i with INT_SOURCE=0x5 -> writes 0x404=0xF000, 0x400=0x0020F800; read 0x004; write 0x004=0x5; RXBD read returns 0x00246000 -> rx_len_o=0x24, status_o=0x05, done_o one pulse.
- INT_SOURCE=0x1 first, then 0x4 on a second interrupt -> two clear writes (0x1, then 0x4); done only after the second; status_o=0x05.
- eth_int_i never asserted, TIMEOUT_CYC=50 -> done_o after 50 WAIT_IRQ cycles, timeout_o=1, no 0x600 access.
- start_i pulsed during init and during WAIT_IRQ -> ignored; no extra TX_PTR write.
- arst_n_i low while waiting for m_ready_i -> m_valid_o=0 immediately; after release, the init sequence restarts from the 0x008 write.
